echo_indication_pipe: RTL

- Downstream stage of the echo responder: consumes each `echo(v)` indication call and serialises it into a framed 32-bit message stream toward the host portal.
- Buffers up to DEPTH pending calls.
- Emits two beats per call: a header beat (method id and length), then a payload beat.
- Exposes RDY/ENA on the method side and valid/ready/last on the stream side.

---
 rtl/echo_indication_pipe_if.sv | 24 ++
 rtl/echo_indication_pipe.sv | 133 +++++++++++++
 2 files changed

// File: rtl/echo_indication_pipe_if.sv
// Bundles the echo method call port and the framed message stream. The
// slave view belongs to the serialiser and the master view to whatever
// drives calls and consumes the stream.
interface echo_indication_pipe_if;
  logic        echo__ENA;
  logic [31:0] echo_v;
  logic        echo__RDY;
  logic [31:0] pipe_data;
  logic        pipe_valid;
  logic        pipe_last;
  logic        pipe_ready;
  logic [15:0] msg_count;
  logic        overflow;

  modport slave (
    input  echo__ENA, echo_v, pipe_ready,
    output echo__RDY, pipe_data, pipe_valid, pipe_last, msg_count, overflow
  );

  modport master (
    output echo__ENA, echo_v, pipe_ready,
    input  echo__RDY, pipe_data, pipe_valid, pipe_last, msg_count, overflow
  );
endinterface

// File: rtl/echo_indication_pipe.sv
// Serialises echo(v) indication calls into two-beat framed messages:
// a header beat {METHOD_ID, length=2} followed by a payload beat holding v.
// Calls wait in a small circular FIFO; the stream side is a registered
// IDLE/HDR/PAY state machine. The FIFO head is popped only when its
// payload beat transfers, so the in-flight entry is never disturbed.
module echo_indication_pipe #(
  parameter int          DEPTH     = 2,
  parameter logic [15:0] METHOD_ID = 16'h0000
) (
  input logic                   CLK,
  input logic                   nRST,
  echo_indication_pipe_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [31:0]      HDR_WORD = {METHOD_ID, 16'd2};

  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             ovf;

  state_t           state;
  logic             vld_p1;
  logic             last_p1;
  logic [31:0]      data_p1;
  logic [15:0]      msg_cnt;

  logic rdy;
  logic enq;
  logic deq;
  logic more_after_pop;

  // Ready comes from registered occupancy only, so a pop in the same cycle
  // cannot open the door for a call.
  assign rdy = (count != FULL_CNT);
  assign enq = bus.echo__ENA & rdy;
  assign deq = (state == PAY) & bus.pipe_ready;
  // PAY implies count >= 1, so something remains if count > 1 or a call lands now.
  assign more_after_pop = (count > ONE_CNT) | enq;

  assign bus.echo__RDY  = rdy;
  assign bus.pipe_valid = vld_p1;
  assign bus.pipe_last  = last_p1;
  assign bus.pipe_data  = data_p1;
  assign bus.msg_count  = msg_cnt;
  assign bus.overflow   = ovf;

  // FIFO storage: written on accept, never reset (pure data).
  always_ff @(posedge CLK) begin
    if (enq) begin
      mem[wr_ptr] <= bus.echo_v;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (enq) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
      if (bus.echo__ENA && !rdy) begin
        ovf <= 1'b1;
      end
    end
  end

  // Stream state machine with registered beat outputs and message counter.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      data_p1 <= '0;
      msg_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state   <= HDR;
            vld_p1  <= 1'b1;
            last_p1 <= 1'b0;
            data_p1 <= HDR_WORD;
          end
        end
        HDR: begin
          if (bus.pipe_ready) begin
            state   <= PAY;
            last_p1 <= 1'b1;
            data_p1 <= mem[rd_ptr];
          end
        end
        PAY: begin
          if (bus.pipe_ready) begin
            msg_cnt <= msg_cnt + 16'd1;
            if (more_after_pop) begin
              state   <= HDR;
              last_p1 <= 1'b0;
              data_p1 <= HDR_WORD;
            end else begin
              state   <= IDLE;
              vld_p1  <= 1'b0;
              last_p1 <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          vld_p1  <= 1'b0;
          last_p1 <= 1'b0;
        end
      endcase
    end
  end
endmodule
